// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock measurement blocks.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    GATE  = 2'd2
  } meas_state_t;

  localparam int CNT_W_DEF = 32;

  // Increment that sticks at the all-ones value of a counter `width` bits wide.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain for an asynchronous input followed by a registered
// rising-edge detector; the edge pulse trails the input by SYNC_STAGES+1 clocks.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      sig_edge <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q   <= sync_q[SYNC_STAGES-1];
      sig_edge <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: reports rising edges of sig_in per GATE_CYCLES window.
// Define CLK_FREQ_METER_PERIOD_EN to add the edge-to-edge period counter.
//
//   state | meaning
//   IDLE  | disabled, waiting for en
//   ALIGN | waiting for the first edge to start the window train
//   GATE  | counting edges; windows repeat back-to-back while en holds
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] period_count,
  output logic             period_valid
);

  localparam int              GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  meas_state_t       state, state_nxt;
  logic              sig_edge;
  logic [GATE_W-1:0] gate_left;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic              ovf;
  logic              sat_hit;
  logic              win_load;
  logic              win_done;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  assign sat_hit   = sig_edge && (edge_cnt == '1);
  assign edge_next = sig_edge ? CNT_W'(sat_inc(64'(edge_cnt), CNT_W)) : edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    win_done  = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = ALIGN;
      ALIGN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (sig_edge) begin
          win_load  = 1'b1;
          state_nxt = GATE;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (gate_left == '0) begin
          win_done = 1'b1;
          win_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate timer is a down-counter; the final cycle both reports and reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_left  <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (win_done) begin
        freq_count <= edge_next;
        overflow   <= ovf | sat_hit;
        freq_valid <= 1'b1;
      end
      if (win_load) begin
        gate_left <= GATE_LAST;
        edge_cnt  <= '0;
        ovf       <= 1'b0;
      end else if (state == GATE) begin
        gate_left <= gate_left - 1'b1;
        edge_cnt  <= edge_next;
        if (sat_hit) ovf <= 1'b1;
      end
    end
  end

`ifdef CLK_FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt;
  logic             per_armed;

  // The first edge after enable only arms; later edges report the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_count <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        per_cnt   <= '0;
        per_armed <= 1'b0;
      end else if (sig_edge) begin
        if (per_armed) begin
          period_count <= per_cnt;
          period_valid <= 1'b1;
        end
        per_cnt   <= CNT_W'(1);
        per_armed <= 1'b1;
      end else begin
        per_cnt <= CNT_W'(sat_inc(64'(per_cnt), CNT_W));
      end
    end
  end
`else
  assign period_count = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measurement counterpart to the clock divider: takes a slow or divided signal (e.g. the divider output, or an external pin) back into the `clk` domain and measures it.
- Counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` `clk` cycles and reports the count once per window.
- Used to check divider ratios on hardware and to drive LED/debug displays.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in `clk` cycles (1 s at 50 MHz); legal range ≥ 2.
- CNT_W, 32, width of the edge counter and period counter.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in`; legal range ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  measurement enable.
- sig_in  input  1  signal under measurement; asynchronous to `clk`.
- freq_count  output  CNT_W  rising edges counted in the last completed window.
- freq_valid  output  1  one-cycle pulse when `freq_count` updates.
- overflow  output  1  the last completed window saturated `freq_count`.
- period_count  output  CNT_W  `clk` cycles between the last two rising edges (optional feature).
- period_valid  output  1  one-cycle pulse when `period_count` updates (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, synchronizer flops 0, edge-detect register 0.
- Input path: `sig_in` passes through SYNC_STAGES flops, then a registered previous-value flop.
  - `edge` = sync_out & ~prev.
  - Latency from `sig_in` rise to `edge` asserted is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE:
    - `en` = 0 → stay.
    - `en` = 1 → ALIGN.
  - ALIGN:
    - Wait for the first `edge`.
    - On `edge`: gate_cnt ← 0, edge_cnt ← 0; that edge is not counted; go to GATE.
  - GATE:
    - Each cycle: gate_cnt += 1; on `edge`, edge_cnt += 1, saturating at 2^CNT_W−1, and a saturation event sets the internal ovf flag.
    - On the cycle where gate_cnt == GATE_CYCLES−1, an `edge` in that cycle is included.
    - Next cycle: freq_count ← final count, overflow ← ovf, freq_valid = 1 for exactly one cycle.
    - The next window starts on that same final cycle: gate_cnt ← 0, edge_cnt ← 0, ovf ← 0. Windows are back-to-back with no dead cycle and no re-align.
- `en` falls in ALIGN or GATE: abort, go to IDLE next cycle, no `freq_valid`. `freq_count` and `overflow` hold their previous values.
- No edges in a window: `freq_count` = 0 and `freq_valid` still pulses.
- `rst` asserted mid-window: immediate return to the reset state; no valid pulse.
- All outputs are registered.

Optional Feature:
- CLK_FREQ_METER_PERIOD_EN defined:
  - A period counter runs whenever `en` = 1, independent of the FSM state.
  - On each `edge`: if a previous edge has been seen since `en` rose, period_count ← cycles since that previous edge, and period_valid pulses for one cycle. The counter then resets to 1.
  - The counter saturates at all-ones.
  - The first edge after `en` rises only arms the counter; no pulse.
- Not defined: `period_count` tied to 0, `period_valid` tied to 0, no counter logic.

Decomposition:
- Package clk_meas_pkg:
  - FSM state enum (IDLE, ALIGN, GATE).
  - Default CNT_W constant.
  - Saturating-increment function.
- Sub-module edge_sync: synchronizer chain plus rising-edge detect, parameterised by SYNC_STAGES; instantiated once.

Test Plan (GATE_CYCLES=100, CNT_W=8, SYNC_STAGES=2 unless stated):
1. Reset: hold `rst` 5 cycles with `sig_in` toggling → all outputs 0; no `freq_valid` while `rst` = 1.
2. `sig_in` square wave with 10-cycle period, `en` = 1 → `freq_valid` pulses every 100 cycles after align; `freq_count` = 10 each window; `overflow` = 0.
3. `sig_in` held 0 for a full window after align → `freq_valid` pulses with `freq_count` = 0.
4. CNT_W=4, `sig_in` period 4 cycles (25 edges/window) → `freq_count` = 15, `overflow` = 1. Next window at 40-cycle period (2–3 edges) → `overflow` = 0.
5. Drop `en` at gate_cnt = 50 → no `freq_valid`; `freq_count` keeps its prior value. Re-raise `en` → ALIGN, then correct counts resume.
6. With CLK_FREQ_METER_PERIOD_EN, `sig_in` period 7 cycles → first edge gives no pulse, then `period_valid` every 7 cycles with `period_count` = 7. Without the macro → both outputs stay 0.
